// File: rtl/i2s_tx_stream_arbiter.sv
// Round-robin scheduler sharing one I2S transmitter between NUM_SRC playback buffers,
// one BUF_LEN-sample burst per grant, prefetching each sample into a hold register.
module i2s_tx_stream_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 24,
  parameter int BUF_LEN = 1024,
  parameter int CNT_W   = $clog2(BUF_LEN + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ws_i,
  input  logic [NUM_SRC-1:0]        src_req_i,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]        src_valid_i,
  output logic [NUM_SRC-1:0]        src_ready_o,
  output logic [NUM_SRC-1:0]        src_done_o,
  output logic [DATA_W-1:0]         tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic                      tx_buffer_ready_o,
  output logic [NUM_SRC-1:0]        grant_o,
  output logic                      busy_o,
  output logic [15:0]               underrun_cnt_o
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, ANNOUNCE, STREAM, DRAIN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  hold;
  logic [DATA_W-1:0]  sel_data;
  logic               ws_d;
  logic               ws_edge;
  logic               xfer;
  int                 cand;

  // Scan from the highest offset down so the nearest requester after last_grant wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      cand = (int'(last_grant) + 1 + i) % NUM_SRC;
      if (src_req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  assign sel_data  = src_data_i[gidx*DATA_W +: DATA_W];
  assign xfer      = |(src_ready_o & src_valid_i);
  assign ws_edge   = ws_d != ws_i;
  assign tx_data_o = hold;
  assign busy_o    = state != IDLE;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      gidx              <= '0;
      last_grant        <= IDX_W'(NUM_SRC - 1);
      count             <= '0;
      hold              <= '0;
      ws_d              <= 1'b0;
      grant_o           <= '0;
      src_ready_o       <= '0;
      src_done_o        <= '0;
      tx_valid_o        <= 1'b0;
      tx_buffer_ready_o <= 1'b0;
      underrun_cnt_o    <= '0;
    end else begin
      ws_d              <= ws_i;
      src_done_o        <= '0;
      tx_buffer_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gidx        <= pick_idx;
            grant_o     <= NUM_SRC'(1) << pick_idx;
            src_ready_o <= NUM_SRC'(1) << pick_idx;
            count       <= CNT_W'(BUF_LEN);
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (xfer) begin
            hold              <= sel_data;
            tx_valid_o        <= 1'b1;
            src_ready_o       <= '0;
            tx_buffer_ready_o <= 1'b1;
            state             <= ANNOUNCE;
          end
        end
        ANNOUNCE: state <= STREAM;
        STREAM: begin
          // A refill transfer only happens while the hold register is empty,
          // so it can never coincide with a consumed request.
          if (xfer) begin
            hold        <= sel_data;
            tx_valid_o  <= 1'b1;
            src_ready_o <= '0;
          end
          if (tx_ready_i) begin
            if (tx_valid_o) begin
              count      <= count - CNT_W'(1);
              tx_valid_o <= 1'b0;
              if (count == CNT_W'(1)) state <= DRAIN;
              else                    src_ready_o <= grant_o;
            end else if (underrun_cnt_o != 16'hFFFF) begin
              underrun_cnt_o <= underrun_cnt_o + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (ws_edge) begin
            src_done_o <= grant_o;
            last_grant <= gidx;
            grant_o    <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tx_stream_arbiter.sv
// Directed bench for i2s_tx_stream_arbiter: reset, bursts, round-robin order,
// underrun/saturation and the WS-aligned grant release.
module tb_i2s_tx_stream_arbiter;
  localparam int NS  = 4;
  localparam int DW  = 24;
  localparam int BUF = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            ws_i = 1'b0;
  logic [NS-1:0]   src_req_i = '0;
  logic [NS*DW-1:0] src_data_i;
  logic [NS-1:0]   src_valid_i = '1;
  logic [NS-1:0]   src_ready_o;
  logic [NS-1:0]   src_done_o;
  logic [DW-1:0]   tx_data_o;
  logic            tx_valid_o;
  logic            tx_ready_i = 1'b0;
  logic            tx_buffer_ready_o;
  logic [NS-1:0]   grant_o;
  logic            busy_o;
  logic [15:0]     underrun_cnt_o;

  i2s_tx_stream_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .BUF_LEN(BUF)) dut (
    .clk_i(clk), .rst_i(rst_i), .ws_i(ws_i),
    .src_req_i(src_req_i), .src_data_i(src_data_i), .src_valid_i(src_valid_i),
    .src_ready_o(src_ready_o), .src_done_o(src_done_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .tx_buffer_ready_o(tx_buffer_ready_o), .grant_o(grant_o), .busy_o(busy_o),
    .underrun_cnt_o(underrun_cnt_o)
  );

  always #5 clk = ~clk;

  // Source model: source k presents base[k] + (samples already popped) + 1.
  logic [DW-1:0] src_base [NS];
  logic [DW-1:0] src_idx  [NS];
  logic [DW-1:0] exp_idx  [NS];
  logic          tb_clr = 1'b0;

  initial for (int k = 0; k < NS; k++) begin
    src_idx[k] = '0;
    exp_idx[k] = '0;
    src_base[k] = DW'(k << 20);
  end

  always_comb
    for (int k = 0; k < NS; k++)
      src_data_i[k*DW +: DW] = src_base[k] + src_idx[k] + DW'(1);

  always @(posedge clk)
    for (int k = 0; k < NS; k++)
      if (tb_clr) src_idx[k] <= '0;
      else if (src_ready_o[k] && src_valid_i[k]) src_idx[k] <= src_idx[k] + DW'(1);

  int tbr_cnt = 0, done_cnt = 0, onehot_err = 0, overlap_err = 0;
  bit outstanding = 1'b0;

  always @(negedge clk) begin
    if ($countones(grant_o) > 1) onehot_err++;
    if (rst_i) outstanding = 1'b0;
    if (tx_buffer_ready_o) begin
      tbr_cnt++;
      if (outstanding) overlap_err++;
      outstanding = 1'b1;
    end
    if (|src_done_o) begin
      done_cnt++;
      outstanding = 1'b0;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_req();
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
  endtask

  // Wait (bounded) for a valid sample, check it, then consume it.
  task automatic req_check(input int k, input int gap);
    int t;
    repeat (gap) tick();
    t = 0;
    while (!tx_valid_o && t < 50) begin tick(); t++; end
    chk("tx_data", 32'(tx_data_o), 32'(src_base[k] + exp_idx[k] + DW'(1)));
    exp_idx[k] = exp_idx[k] + DW'(1);
    tx_req();
  endtask

  task automatic do_burst(input int k, input int gap, input bit drop);
    int t;
    t = 0;
    while (grant_o == '0 && t < 20) begin tick(); t++; end
    chk("grant", 32'(grant_o), 32'(1 << k));
    chk("src_ready_fetch", 32'(src_ready_o), 32'(1 << k));
    if (drop) src_req_i = '0;
    t = 0;
    while (!tx_buffer_ready_o && t < 20) begin tick(); t++; end
    chk("buf_ready", 32'(tx_buffer_ready_o), 32'd1);
    tick();
    chk("buf_ready_pulse", 32'(tx_buffer_ready_o), 32'd0);
    for (int s = 0; s < BUF; s++) req_check(k, gap);
    chk("drain_valid", 32'(tx_valid_o), 32'd0);
    chk("drain_src_ready", 32'(src_ready_o), 32'd0);
    repeat (3) tick();
    chk("drain_hold_grant", 32'(grant_o), 32'(1 << k));
    ws_i = ~ws_i;
    tick();
    chk("done_pulse", 32'(src_done_o), 32'(1 << k));
    chk("grant_release", 32'(grant_o), 32'd0);
  endtask

  int done_before;

  initial begin
    // Power-on reset
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_tx", {tx_valid_o, tx_buffer_ready_o, tx_data_o}, 32'd0);
    chk("rst_src", {src_ready_o, src_done_o}, 32'd0);
    chk("rst_underrun", 32'(underrun_cnt_o), 32'd0);

    // Single source 2, samples 1..4, one request every 64 cycles; request dropped mid-grant
    src_base[2] = '0;
    src_req_i = 4'b0100;
    tick();
    do_burst(2, 63, 1'b1);
    tick();
    chk("done_one_cycle", 32'(src_done_o), 32'd0);
    chk("single_tbr_count", 32'(tbr_cnt), 32'd1);
    chk("idle_after_done", 32'(busy_o), 32'd0);

    // Reset mid-STREAM of source 3: burst abandoned, priority back to source 0
    src_req_i = 4'b1000;
    tick(); tick(); tick();
    chk("pre_rst_grant", 32'(grant_o), 32'b1000);
    req_check(3, 0);
    done_before = done_cnt;
    src_req_i = '0;
    rst_i = 1'b1; tb_clr = 1'b1;
    tick(); tick();
    chk("mid_rst_grant", 32'(grant_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_tx", {tx_valid_o, tx_buffer_ready_o, tx_data_o}, 32'd0);
    chk("mid_rst_src", {src_ready_o, src_done_o}, 32'd0);
    rst_i = 1'b0; tb_clr = 1'b0;
    for (int k = 0; k < NS; k++) exp_idx[k] = '0;
    tick();
    chk("no_done_on_rst", 32'(done_cnt), 32'(done_before));

    // Round-robin with requests 1011 held: 0,1,3,0
    src_req_i = 4'b1011;
    do_burst(0, 1, 1'b0);
    do_burst(1, 2, 1'b0);
    do_burst(3, 0, 1'b0);
    do_burst(0, 1, 1'b0);
    src_req_i = '0;
    tick();
    chk("rr_idle", 32'(busy_o), 32'd0);

    // Underrun: source 1 stalls after its first sample
    src_req_i = 4'b0010;
    tick();
    chk("ur_grant", 32'(grant_o), 32'b0010);
    src_req_i = '0;
    tick(); tick();
    req_check(1, 0);
    src_valid_i[1] = 1'b0;
    repeat (3) begin tick(); tx_req(); end
    chk("ur_count", 32'(underrun_cnt_o), 32'd3);
    chk("ur_valid", 32'(tx_valid_o), 32'd0);
    chk("ur_refill_ready", 32'(src_ready_o), 32'b0010);
    src_valid_i[1] = 1'b1;
    repeat (BUF - 1) req_check(1, 1);
    chk("ur_drain_grant", 32'(grant_o), 32'b0010);
    chk("ur_drain_ready", 32'(src_ready_o), 32'd0);
    ws_i = ~ws_i;
    tick();
    chk("ur_done", 32'(src_done_o), 32'b0010);

    // Saturation: source 3 stalls while the transmitter requests every cycle
    src_req_i = 4'b1000;
    tick();
    chk("sat_grant", 32'(grant_o), 32'b1000);
    src_req_i = '0;
    tick(); tick();
    req_check(3, 0);
    src_valid_i[3] = 1'b0;
    tx_ready_i = 1'b1;
    repeat (70000) tick();
    tx_ready_i = 1'b0;
    chk("sat_underrun", 32'(underrun_cnt_o), 32'hFFFF);
    src_valid_i[3] = 1'b1;
    repeat (BUF - 1) req_check(3, 1);

    // Drain boundary: ws toggles 10 cycles after the last request, competitor waiting
    repeat (10) tick();
    chk("db_still_granted", 32'(grant_o), 32'b1000);
    chk("db_busy", 32'(busy_o), 32'd1);
    src_req_i = 4'b0011;
    ws_i = ~ws_i;
    tick();
    chk("db_release", 32'(grant_o), 32'd0);
    chk("db_done", 32'(src_done_o), 32'b1000);
    tick();
    chk("db_next_grant", 32'(grant_o), 32'b0001);

    chk("onehot_grant", 32'(onehot_err), 32'd0);
    chk("no_overlap_bursts", 32'(overlap_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
